// File: rtl/gate_chk_pkg.sv
// Purpose : shared types and constants for the 2-input gate response checker.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package gate_chk_pkg;

  // {a,b} vector width and internal counter widths.
  localparam int VEC_W    = 2;
  localparam int SETTLE_W = 4;   // holds settle counts 0..15
  localparam int PASS_W   = 8;   // holds sweep counts 1..255

  // Expected-y truth tables, bit index = {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Expected gate output for one input vector.
  function automatic logic expected_y(input logic [3:0] tt, input logic [VEC_W-1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/gate_chk_settle_timer.sv
// Purpose : loadable down-counter flagging the last settle cycle.
// Latency : load takes effect on the next clock; tc_o is combinational from the count.
// Backpressure: none; dec_i is ignored when the count is already zero.
// Ports: clk/rst_n clock and async reset; load_i/load_val_i load the count;
//        dec_i decrements by one; tc_o is high while the count equals 1.
module gate_chk_settle_timer
  import gate_chk_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count at 1 so the owner leaves WAIT after exactly the loaded count.
  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/gate_response_checker.sv
// Purpose : drives all four {a,b} vectors into a 2-input gate, checks y against a truth table.
// Latency : SETTLE_CYCLES+2 clocks per vector; done rises the clock after the final check.
// Backpressure: none; start is ignored while busy, accepted only in IDLE or DONE.
// Ports: clk/rst_n clock and async active-low reset; start begins a run;
//        dut_a/dut_b drive the gate, dut_y is its output; busy/done/pass report status;
//        err_count counts (saturating) mismatches, fail_valid pulses per mismatch,
//        last_fail_vec holds {a,b} of the most recent mismatch.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NOR,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] last_fail_vec
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [PASS_W-1:0]   PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [VEC_W-1:0]    VEC_LAST  = '1;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   last_q, last_d;
  logic [VEC_W-1:0]   dut_ab_q, dut_ab_d;

  logic timer_load;
  logic timer_dec;
  logic timer_tc;
  logic mismatch;

  gate_chk_settle_timer #(.W(SETTLE_W)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (timer_dec),
    .tc_o       (timer_tc)
  );

  assign mismatch = (dut_y != expected_y(TRUTH_TABLE, vec_q));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    last_d     = last_q;
    dut_ab_d   = dut_ab_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    fail_valid = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // dut_a/b keep their last value until APPLY registers vector 00.
        if (start) begin
          vec_d      = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          last_d     = '0;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        dut_ab_d   = vec_q;
        timer_load = 1'b1;
        state_d    = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_tc) begin
          state_d = ST_CHECK;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_valid = 1'b1;
          last_d     = vec_q;
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_APPLY;
        end else if (pass_cnt_q < PASS_LAST) begin
          vec_d      = '0;
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          state_d    = ST_APPLY;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      err_q      <= '0;
      last_q     <= '0;
      dut_ab_q   <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      last_q     <= last_d;
      dut_ab_q   <= dut_ab_d;
    end
  end

  assign dut_a         = dut_ab_q[1];
  assign dut_b         = dut_ab_q[0];
  assign busy          = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_q == '0);
  assign err_count     = err_q;
  assign last_fail_vec = last_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Purpose : self-checking bench for gate_response_checker (default and 100-pass instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_gate_response_checker;

  logic       clk;
  logic       rst_n;

  // Instance 1: defaults (NOR table, settle 2, 1 pass), gate modelled by gate_tt.
  logic       start;
  logic       dut_a, dut_b, dut_y;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [1:0] last_fail_vec;
  logic [3:0] gate_tt;

  // Instance 2: NOR table, settle 0, 100 passes, OR gate wired in.
  logic       start2;
  logic       dut_a2, dut_b2, dut_y2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [7:0] err_count2;
  logic [1:0] last_fail_vec2;

  int n_chk;
  int n_fail;

  assign dut_y  = gate_tt[{dut_a, dut_b}];
  assign dut_y2 = dut_a2 | dut_b2;

  gate_response_checker u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dut_a         (dut_a),
    .dut_b         (dut_b),
    .dut_y         (dut_y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .fail_valid    (fail_valid),
    .last_fail_vec (last_fail_vec)
  );

  gate_response_checker #(
    .TRUTH_TABLE   (4'b0001),
    .SETTLE_CYCLES (0),
    .PASSES        (100),
    .ERR_W         (8)
  ) u_dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start2),
    .dut_a         (dut_a2),
    .dut_b         (dut_b2),
    .dut_y         (dut_y2),
    .busy          (busy2),
    .done          (done2),
    .pass          (pass2),
    .err_count     (err_count2),
    .fail_valid    (fail_valid2),
    .last_fail_vec (last_fail_vec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One run of instance 1 against the NOR reference table, checking every cycle.
  task automatic run1(input logic [3:0] tt, input int exp_err, input logic [1:0] exp_last,
                      input logic exp_pass, input bit repulse);
    localparam int S = 2;
    localparam int P = 1;
    int         n_run;
    int         c;
    int         pulses;
    int         v;
    logic [3:0] ref_tt;
    ref_tt = 4'b0001;
    n_run  = 4 * P * (S + 2);
    gate_tt = tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);          // cycle 0: first cycle after the start-sampling edge
    start = 1'b0;
    c = 0;
    pulses = 0;
    while (!done && c < 200) begin
      if (c < n_run) check("busy_in_run", int'(busy), 1);
      if (c == 0) check("err_cleared_at_start", int'(err_count), 0);
      if (fail_valid) pulses++;
      if ((c % (S + 2)) == S + 1) begin
        v = (c / (S + 2)) % 4;
        check("dut_vector", int'({dut_a, dut_b}), v);
        check("fail_valid_on_check", int'(fail_valid), int'(tt[v] != ref_tt[v]));
      end
      if (repulse && c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(negedge clk);
      c++;
    end
    // Edges counted including the start-sampling edge.
    check("done_latency", c + 1, n_run + 1);
    check("done_busy_low", int'(busy), 0);
    check("err_count", int'(err_count), exp_err);
    check("last_fail_vec", int'(last_fail_vec), int'(exp_last));
    check("pass", int'(pass), int'(exp_pass));
    check("fail_pulses", pulses, exp_err);
    check("dut_hold_11", int'({dut_a, dut_b}), 3);
  endtask

  typedef struct {
    logic [3:0] tt;
    int         exp_err;
    logic [1:0] exp_last;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int         c;
    int         pulses;
    logic [3:0] rtt;
    logic [3:0] nor_tt;
    int         m_err;
    logic [1:0] m_last;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    gate_tt = 4'b0001;

    // Gate under test vs NOR reference: error count, last failing {a,b}, pass.
    tbl[0] = '{4'b0001, 0, 2'd0, 1'b1};  // correct NOR
    tbl[1] = '{4'b1110, 4, 2'd3, 1'b0};  // OR
    tbl[2] = '{4'b0000, 1, 2'd0, 1'b0};  // stuck at 0
    tbl[3] = '{4'b1000, 2, 2'd3, 1'b0};  // AND
    tbl[4] = '{4'b0110, 3, 2'd2, 1'b0};  // XOR
    tbl[5] = '{4'b0111, 2, 2'd2, 1'b0};  // NAND
    tbl[6] = '{4'b1001, 1, 2'd3, 1'b0};  // XNOR

    #13;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail_valid", int'(fail_valid), 0);
    check("rst_last", int'(last_fail_vec), 0);
    check("rst_dut_ab", int'({dut_a, dut_b}), 0);
    check("rst_done2", int'(done2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run1(tbl[i].tt, tbl[i].exp_err, tbl[i].exp_last, tbl[i].exp_pass, 1'b0);
    end

    // start re-pulsed mid-run is ignored; the run keeps its schedule.
    run1(4'b1110, 4, 2'd3, 1'b0, 1'b1);

    // Random gates against a truth-table model.
    nor_tt = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      rtt    = 4'($urandom_range(0, 15));
      m_err  = 0;
      m_last = 2'd0;
      for (int v = 0; v < 4; v++) begin
        if (rtt[v] != nor_tt[v]) begin
          m_err++;
          m_last = 2'(v);
        end
      end
      run1(rtt, m_err, m_last, (m_err == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset during WAIT of vector 10 with errors accumulated.
    gate_tt = 4'b1110;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_err", int'(err_count), 2);
    check("pre_rst_vec", int'({dut_a, dut_b}), 2);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err_count), 0);
    check("mid_rst_last", int'(last_fail_vec), 0);
    check("mid_rst_dut_ab", int'({dut_a, dut_b}), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run1(4'b0001, 0, 2'd0, 1'b1, 1'b0);

    // 100 sweeps, settle 0, OR gate: saturation and long-run timing.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    c = 0;
    pulses = 0;
    while (!done2 && c < 3000) begin
      if (fail_valid2) pulses++;
      @(negedge clk);
      c++;
    end
    check("p100_done_latency", c + 1, 4 * 100 * (0 + 2) + 1);
    check("p100_fail_pulses", pulses, 400);
    check("p100_err_saturated", int'(err_count2), 255);
    check("p100_last", int'(last_fail_vec2), 3);
    check("p100_pass", int'(pass2), 0);
    check("p100_busy", int'(busy2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable, self-checking response checker for the 2-input gate DUTs (AND/OR/NOR/NAND/XOR/XNOR) in the daily gate blocks.
- Sweeps all four input combinations into the DUT and waits a settle time.
- Samples the DUT output and compares it against an expected truth table, counting mismatches.
- Sits opposite the gate: it drives the gate's a/b, consumes y and reports pass/fail, so gate checks run in hardware or in any bench without manual waveform inspection.

Parameters:
- TRUTH_TABLE, 4'b0001, expected y indexed by {a,b}; bit0 = vector 00 … bit3 = vector 11. Default is NOR.
- SETTLE_CYCLES, 2, clocks between applying a vector and sampling y. Legal range 0..15.
- PASSES, 1, number of full 4-vector sweeps per run. Legal range 1..255.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_a  out  1  DUT input a.
- dut_b  out  1  DUT input b.
- dut_y  in  1  DUT output. Combinational from dut_a/dut_b, same clock domain, no synchronizer.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high from run completion until the next start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ERR_W  mismatches in the current/last run; saturates at all-ones.
- fail_valid  out  1  one-cycle pulse on each mismatch.
- last_fail_vec  out  2  {a,b} of the most recent mismatch; holds its value between failures.

Behaviour:
- Reset (asynchronous, any time, including mid-run): all outputs and state go to 0, FSM to IDLE, dut_a=dut_b=0. No partial result survives.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE: start=1 -> APPLY. On entry, vector=0, pass_cnt=0, err_count=0, last_fail_vec=0.
- APPLY (1 cycle): register {dut_a,dut_b}=vector and load settle_cnt=SETTLE_CYCLES. If SETTLE_CYCLES==0, go straight to CHECK; otherwise -> WAIT.
- WAIT: decrement settle_cnt each clock. Go to CHECK on the cycle settle_cnt reaches 1, so WAIT lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): compare dut_y with TRUTH_TABLE[vector].
  - On mismatch: fail_valid=1 that cycle, last_fail_vec=vector, err_count+1 unless already all-ones.
  - Then:
    - vector<3: vector+1 -> APPLY.
    - vector==3 and pass_cnt<PASSES-1: vector wraps to 0, pass_cnt+1 -> APPLY.
    - Otherwise -> DONE.
- DONE:
  - done=1, busy=0, pass=(err_count==0).
  - dut_a/dut_b hold the final vector (2'b11).
  - start=1 -> clears done/err_count/last_fail_vec and enters APPLY on the next clock with vector 00.
- busy=1 in APPLY, WAIT and CHECK. start is ignored while busy.
- Timing per vector: SETTLE_CYCLES+2 clocks. Per run: 4*PASSES*(SETTLE_CYCLES+2) clocks.
  - done rises on the clock after the final CHECK.
  - Defaults: 17 clocks after the start-sampling edge.
- Vector order is fixed: 00, 01, 10, 11 ({a,b}).
- err_count saturation: at all-ones it holds. fail_valid and last_fail_vec still update.

Decomposition:
- Package gate_chk_pkg:
  - state enum (IDLE/APPLY/WAIT/CHECK/DONE);
  - VEC_W=2;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_NAND=4'b0111, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- Sub-module: gate_chk_settle_timer, a loadable down-counter with a terminal-count output, used for WAIT.

Test Plan:
- Correct NOR DUT, defaults, start pulse -> dut_a/b sequence 00,01,10,11; done high 17 clocks after start edge; pass=1; err_count=0; fail_valid never asserted.
- OR gate wired in place of NOR -> 4 fail_valid pulses, one per CHECK; err_count=4; last_fail_vec=2'b11; pass=0.
- dut_y stuck at 0 with NOR table -> single mismatch on vector 00; err_count=1; last_fail_vec=2'b00; pass=0.
- rst_n low during WAIT of vector 10 -> all outputs 0 immediately without waiting for clk; start afterwards runs a full clean sweep to pass=1.
- start re-pulsed while busy -> ignored, run completes on schedule. start in DONE -> err_count/done cleared and a new sweep begins.
- PASSES=100, ERR_W=8, OR DUT -> 400 mismatches, err_count saturates at 255, fail_valid pulses 400 times; with SETTLE_CYCLES=0, done rises 801 clocks after the start edge.
